// File: rtl/fetch_execute_sequencer_if.sv
// Memory and ALU bus between the fetch/execute sequencer (master) and the
// surrounding memory and ALU (slave).
//
// Bus protocol: there is no valid/ready pair.  The master presents mem_addr
// every cycle and the memory samples it on the rising edge.  With mem_we=0 the
// addressed word appears on mem_rdata during the following cycle.  With
// mem_we=1 the memory writes mem_wdata at that edge.  mem_we is high for
// exactly one cycle per store and is never held.  The ALU is purely
// combinational: alu_result follows alu_op/alu_a/alu_b in the same cycle.
interface fetch_execute_sequencer_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output alu_op,
        output alu_a,
        output alu_b,
        input  mem_rdata,
        input  alu_result
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  alu_op,
        input  alu_a,
        input  alu_b,
        output mem_rdata,
        output alu_result
    );
endinterface

// File: rtl/fetch_execute_sequencer.sv
// Fetch/execute sequencer for a small accumulator machine.
// Instruction word: opcode in [15:12], 12-bit operand X in [11:0]; the
// effective byte address is {4'b0, X}.  Instructions are 2 bytes, so PC
// advances by 2 per fetch and wraps modulo 2^16.
// state_dbg and mbr_dbg expose internal state for observation only.
module fetch_execute_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    fetch_execute_sequencer_if.master         bus,
    output logic [15:0]                       pc,
    output logic [15:0]                       ac,
    output logic [15:0]                       ir,
    output logic                              instr_done,
    output logic                              illegal,
    output logic                              halted,
    output logic [2:0]                        state_dbg,
    output logic [15:0]                       mbr_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOADIR = 3'd2,
        S_DECODE = 3'd3,
        S_READ   = 3'd4,
        S_EXEC   = 3'd5,
        S_WRITE  = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_LOAD     = 4'h1;
    localparam logic [3:0] OP_STORE    = 4'h2;
    localparam logic [3:0] OP_ADD      = 4'h3;
    localparam logic [3:0] OP_SUBT     = 4'h4;
    localparam logic [3:0] OP_HALT     = 4'h7;
    localparam logic [3:0] OP_SKIPCOND = 4'h8;
    localparam logic [3:0] OP_JUMP     = 4'h9;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    state_t      state;
    logic [15:0] pc_q;
    logic [15:0] ac_q;
    logic [15:0] ir_q;
    logic [15:0] mar_q;
    logic [15:0] mbr_q;
    logic        mem_we_q;
    logic        halted_q;

    logic [3:0]  opcode;
    logic [15:0] operand_ea;
    logic        op_needs_read;
    logic        op_illegal;
    logic        op_done_at_decode;
    logic        skip_taken;

    assign opcode     = ir_q[15:12];
    assign operand_ea = {4'b0000, ir_q[11:0]};

    // Opcode classification and the SKIPCOND condition (AC viewed as signed).
    always_comb begin
        op_needs_read     = 1'b0;
        op_illegal        = 1'b0;
        op_done_at_decode = 1'b0;
        skip_taken        = 1'b0;
        case (opcode)
            OP_LOAD, OP_ADD, OP_SUBT: op_needs_read = 1'b1;
            OP_STORE:                 op_needs_read = 1'b0;
            OP_NOP, OP_HALT,
            OP_SKIPCOND, OP_JUMP:     op_done_at_decode = 1'b1;
            default: begin
                op_illegal        = 1'b1;
                op_done_at_decode = 1'b1;
            end
        endcase
        case (ir_q[11:10])
            2'b00:   skip_taken = ac_q[15];
            2'b01:   skip_taken = (ac_q == 16'h0000);
            2'b10:   skip_taken = !ac_q[15] && (ac_q != 16'h0000);
            default: skip_taken = 1'b0;
        endcase
    end

    // Sequencer: one state per bus phase; reset aborts any instruction at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            pc_q     <= RESET_PC;
            ac_q     <= 16'h0000;
            ir_q     <= 16'h0000;
            mar_q    <= 16'h0000;
            mbr_q    <= 16'h0000;
            mem_we_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            // mem_we is asserted only for the single WRITE cycle.
            mem_we_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_LOADIR;
                end
                S_LOADIR: begin
                    ir_q  <= bus.mem_rdata;
                    pc_q  <= pc_q + 16'd2;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    mar_q <= operand_ea;
                    if (op_needs_read) begin
                        state <= S_READ;
                    end else if (opcode == OP_STORE) begin
                        mem_we_q <= 1'b1;
                        state    <= S_WRITE;
                    end else if (opcode == OP_JUMP) begin
                        pc_q  <= operand_ea;
                        state <= S_FETCH;
                    end else if (opcode == OP_SKIPCOND) begin
                        if (skip_taken) begin
                            pc_q <= pc_q + 16'd2;
                        end
                        state <= S_FETCH;
                    end else if (opcode == OP_HALT) begin
                        halted_q <= 1'b1;
                        state    <= S_HALT;
                    end else begin
                        // NOP and illegal opcodes leave all registers alone.
                        state <= S_FETCH;
                    end
                end
                S_READ: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    mbr_q <= bus.mem_rdata;
                    if (opcode == OP_LOAD) begin
                        ac_q <= bus.mem_rdata;
                    end else begin
                        ac_q <= bus.alu_result;
                    end
                    state <= S_FETCH;
                end
                S_WRITE: begin
                    state <= S_FETCH;
                end
                S_HALT: begin
                    // Only reset leaves HALT; start is ignored here.
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Operand phases address MAR; every other phase keeps PC on the bus.
    assign bus.mem_addr  = ((state == S_READ) || (state == S_WRITE)) ? mar_q : pc_q;
    assign bus.mem_wdata = ac_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.alu_op    = ((state == S_EXEC) && (opcode == OP_SUBT)) ? ALU_SUB : ALU_ADD;
    assign bus.alu_a     = ac_q;
    assign bus.alu_b     = bus.mem_rdata;

    assign instr_done = ((state == S_DECODE) && op_done_at_decode) ||
                        (state == S_EXEC) || (state == S_WRITE);
    assign illegal    = (state == S_DECODE) && op_illegal;
    assign halted     = halted_q;

    assign pc        = pc_q;
    assign ac        = ac_q;
    assign ir        = ir_q;
    assign state_dbg = state;
    assign mbr_dbg   = mbr_q;

endmodule

// File: doc/fetch_execute_sequencer.md
FETCH_EXECUTE_SEQUENCER -- requirements
Module: fetch_execute_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  leaves IDLE when high for one cycle; ignored in other states.
REQ-005 SHALL have port mem_addr  output  16  byte address to main memory, sampled by memory on the rising edge.
REQ-006 SHALL have port mem_wdata  output  16  write data; always equals AC.
REQ-007 SHALL have port mem_we  output  1  memory write enable.
REQ-008 SHALL have port mem_rdata  input  16  memory read data, valid the cycle after mem_addr is presented with mem_we=0.
REQ-009 SHALL have port alu_op  output  4  ALU opcode: 4'b0000 add, 4'b0001 subtract.
REQ-010 SHALL have ports alu_a and alu_b  output  16 each; alu_a=AC, alu_b=mem_rdata.
REQ-011 SHALL have port alu_result  input  16  combinational ALU result.
REQ-012 SHALL have ports pc, ac, ir  output  16 each  architectural register values.
REQ-013 SHALL have ports instr_done, illegal  output  1 each  single-cycle pulses.
REQ-014 SHALL have port halted  output  1  high while in HALT.

Function
REQ-015 Instruction format SHALL be opcode=IR[15:12], operand X=IR[11:0], with effective address {4'b0,X}.
REQ-016 States SHALL be IDLE, FETCH, LOADIR, DECODE, READ, EXEC, WRITE, HALT.
REQ-017 IDLE: mem_we=0; transitions to FETCH when start=1.
REQ-018 FETCH: mem_addr=PC, mem_we=0; transitions to LOADIR.
REQ-019 LOADIR: IR<=mem_rdata; PC<=PC+2 modulo 2^16 (16'hFFFE wraps to 16'h0000); transitions to DECODE.
REQ-020 DECODE: MAR<={4'b0,X}; next state SHALL follow from the opcode per REQ-021..REQ-026.
REQ-021 Opcodes 1 (LOAD), 3 (ADD), 4 (SUBT) SHALL transition to READ.
REQ-022 Opcode 2 (STORE) SHALL transition to WRITE.
REQ-023 Opcode 9 (JUMP): PC<={4'b0,X}, instr_done=1, next FETCH.
REQ-024 Opcode 8 (SKIPCOND), with AC treated as signed: IR[11:10]=00 skips if AC<0; 01 skips if AC==0; 10 skips if AC>0; 11 never skips. A skip SHALL apply PC<=PC+2. instr_done=1; next FETCH.
REQ-025 Opcode 7 (HALT): instr_done=1; next HALT. Opcode 0 (NOP): instr_done=1; next FETCH.
REQ-026 Opcodes 5, 6, 10..15: illegal=1 and instr_done=1 for one cycle; no architectural change; next FETCH.
REQ-027 READ: mem_addr=MAR, mem_we=0; transitions to EXEC.
REQ-028 EXEC: MBR<=mem_rdata. LOAD: AC<=mem_rdata. ADD: alu_op=0000, AC<=alu_result. SUBT: alu_op=0001, AC<=alu_result. instr_done=1; next FETCH.
REQ-029 WRITE: mem_addr=MAR, mem_we=1 for exactly this cycle; instr_done=1; next FETCH.
REQ-030 mem_we SHALL be 0 in every state except WRITE.
REQ-031 alu_op SHALL be 4'b0000 in every state except EXEC of SUBT.
REQ-032 mem_addr SHALL be PC in every state other than READ and WRITE.
REQ-033 Arithmetic SHALL be 16-bit modulo; overflow is discarded without any flag.
REQ-034 Cycles from FETCH entry to the next FETCH entry: JUMP, SKIPCOND and NOP/illegal 3; STORE 4; LOAD/ADD/SUBT 5.
REQ-035 HALT SHALL be exited only by reset; start is ignored in HALT.

Reset
REQ-036 While reset=1, asynchronously: state=IDLE, PC=RESET_PC, AC=IR=MAR=MBR=0, mem_we=0, instr_done=illegal=halted=0.
REQ-037 Reset asserted mid-instruction (including WRITE) SHALL abort the instruction immediately, and mem_we SHALL fall in the same cycle.

Verification
REQ-038 Memory: 0x0000=16'h1010 (LOAD 0x010), 0x0002=16'h3012 (ADD 0x012), 0x0004=16'h2014 (STORE 0x014), 0x0006=16'h7000 (HALT); 0x010=5, 0x012=7. Pulse start -> mem[0x014]=12, ac=12, halted=1, pc=0x0008; instr_done pulses 4 times.
REQ-039 LOAD of 16'h0000 followed by SUBT of 16'h0001 -> ac=16'hFFFF; next SKIPCOND 16'h8000 -> pc advances by 4; next SKIPCOND 16'h8800 -> pc advances by 2.
REQ-040 JUMP 16'h9FFE placed at 0x0FFC -> pc=0x0FFE after 3 cycles; with RESET_PC=16'hFFFE, the fetch from 0xFFFE -> pc wraps to 0x0000.
REQ-041 Instruction 16'hB123 -> illegal=1 for one cycle; ac and memory unchanged; next fetch comes from pc+2.
REQ-042 Reset asserted during the WRITE state of a STORE -> mem_we=0 immediately; state=IDLE; pc=RESET_PC; start required to resume.
REQ-043 Start held high in HALT -> no fetches and halted stays 1; LOAD issued with start low after reset -> no fetch until start is asserted.
